mmio_io_hub: RTL and testbench
==============================

// Module: mmio_io_hub
// PURPOSE
// Parametrised memory-mapped IO hub between the CPU data port and board IO (switches, LEDs, 7-seg).
// Replaces the fixed single-cycle IO decode with a req/rsp handshake, configurable wait states,
// N LED channels, debounced switch inputs with sticky rising-edge flags, and a 7-seg value/enable register.
// The CPU stalls while req_ready is low and takes its read data on rsp_valid.
// PARAMETERS
// IO_BASE      32'hFFFF_FC00  base address of the 1 KiB IO window (byte address)
// N_OUT        2              number of LED output channels
// OUT_W        16             width of each LED channel
// IN_W         16             switch input width (1..32)
// DEB_CYC      1000           cycles an input change must stay stable before it is accepted (>=2)
// WAIT_STATES  0              extra cycles between request acceptance and response (0..15)
// PORTS
// clk        in   1             system clock, rising edge
// rst        in   1             asynchronous reset, active-high
// req_valid  in   1             CPU access request
// req_we     in   1             1 = write, 0 = read
// req_addr   in   32            byte address, word aligned
// req_wdata  in   32            write data
// req_ready  out  1             hub idle; request accepted when req_valid & req_ready
// rsp_valid  out  1             one-cycle pulse: access complete, rsp_rdata valid for reads
// rsp_rdata  out  32            read data (0 for writes and for unmapped addresses)
// addr_err   out  1             one-cycle pulse with rsp_valid: address unmapped or outside window
// sw_in      in   IN_W          raw asynchronous switch inputs
// led_out    out  N_OUT*OUT_W   LED channel k at bits [k*OUT_W +: OUT_W]
// seg_value  out  32            value for the 7-seg driver
// seg_en     out  1             7-seg display enable
// BEHAVIOUR
// Reset (async): FSM=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, addr_err=0, led_out=0,
//   seg_value=0, seg_en=0, sync flops=0, stable=0, edge flags=0, debounce counter=0.
// Register map (offset = req_addr - IO_BASE, only offsets < 0x400 decode):
//   0x00 SW     RO   {0, stable switches}
//   0x04 SWEDGE R/W1C sticky rising-edge flags per switch bit
//   0x10+4k LEDk RW  k < N_OUT, low OUT_W bits, upper bits read 0
//   0x20 SEGVAL RW   32-bit; 0x24 SEGEN RW bit0
//   Any other offset, an address outside the window, or req_addr[1:0]!=0 -> addr_err; write ignored, read 0.
// FSM: IDLE -> (accept) WAIT if WAIT_STATES>0, else RESP; WAIT counts WAIT_STATES cycles -> RESP; RESP -> IDLE.
//   req_ready=1 only in IDLE; address/we/wdata captured on accept; req_* ignored outside IDLE.
//   Register write and read sample both happen on the edge entering RESP; rsp_valid=1 for the RESP cycle only.
//   Latency: rsp_valid WAIT_STATES+1 cycles after the accept edge; back-to-back throughput 1 per WAIT_STATES+2.
//   rsp_rdata holds its last value until the next response; 0 after a write.
// Switch path: 2-flop synchroniser per bit; one shared counter: synced==stable -> counter=0;
//   else counter++; counter reaching DEB_CYC-1 -> stable<=synced, counter=0. Glitches shorter than DEB_CYC drop.
// Edge flags: bit i set when stable[i] 0->1; write to SWEDGE clears bits where wdata=1;
//   set and clear on same edge -> set wins.
// A read of SWEDGE returns flags as of the RESP edge (pre-clear value not applicable; reads never clear).
// Reset mid-access: transaction aborted, no write committed, no rsp_valid.
// TESTING
// Reset: assert rst async mid-cycle -> all outputs 0, req_ready=1 immediately, seg_en=0.
// WAIT_STATES=0: write 0x0000_A5A5 to IO_BASE+0x10 -> rsp_valid next cycle, led_out[15:0]=0xA5A5; read back 0xA5A5.
// WAIT_STATES=3: read IO_BASE+0x20 after writing 0x1234_5678 -> req_ready low 4 cycles, rsp_valid 4 cycles after accept, rdata 0x1234_5678.
// Debounce DEB_CYC=8: sw_in[0] pulses high 5 cycles -> SW reads 0; held high 12 cycles -> SW=1, SWEDGE bit0=1.
// W1C: SWEDGE=0x3, write 0x1 -> reads 0x2; new rising edge on bit0 on same cycle as clear -> bit0 stays 1.
// Errors: read IO_BASE+0x30, write IO_BASE+0x11, access 0x0000_0100 -> addr_err with rsp_valid, rdata 0, no register changes.

Source files
------------

// File: rtl/mmio_io_hub.sv
// Memory-mapped IO hub: req/rsp handshake with wait states, LED channels,
// debounced switches with sticky rising-edge flags, and 7-seg value/enable.
module mmio_io_hub #(
  parameter logic [31:0] IO_BASE     = 32'hFFFF_FC00,
  parameter int unsigned N_OUT       = 2,
  parameter int unsigned OUT_W       = 16,
  parameter int unsigned IN_W        = 16,
  parameter int unsigned DEB_CYC     = 1000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic                   req_we,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   addr_err,
  input  logic [IN_W-1:0]        sw_in,
  output logic [N_OUT*OUT_W-1:0] led_out,
  output logic [31:0]            seg_value,
  output logic                   seg_en
);

  localparam int unsigned CNT_W      = $clog2(DEB_CYC);
  localparam int unsigned WS_W       = 4;
  localparam logic [31:0] WIN_SIZE   = 32'h0000_0400;
  localparam logic [31:0] OFF_SW     = 32'h0000_0000;
  localparam logic [31:0] OFF_SWEDGE = 32'h0000_0004;
  localparam logic [31:0] OFF_LED    = 32'h0000_0010;
  localparam logic [31:0] OFF_SEGVAL = 32'h0000_0020;
  localparam logic [31:0] OFF_SEGEN  = 32'h0000_0024;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [WS_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              cap_we_q, cap_we_d;
  logic [31:0]       cap_addr_q, cap_addr_d;
  logic [31:0]       cap_wdata_q, cap_wdata_d;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              addr_err_q, addr_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic [OUT_W-1:0]  led_q [N_OUT];
  logic [OUT_W-1:0]  led_d [N_OUT];
  logic [31:0]       seg_value_q, seg_value_d;
  logic              seg_en_q, seg_en_d;

  logic [IN_W-1:0]   sync1_q, sync1_d;
  logic [IN_W-1:0]   sync2_q, sync2_d;
  logic [IN_W-1:0]   stable_q, stable_d;
  logic [CNT_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [IN_W-1:0]   edge_q, edge_d;
  logic [IN_W-1:0]   edge_clr;

  logic              commit;
  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [31:0]       acc_off;
  logic              acc_hit;
  logic [31:0]       acc_rdata;
  logic [N_OUT-1:0]  led_hit;

  // State register and all datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
      rsp_rdata_q <= '0;
      for (int k = 0; k < N_OUT; k++) led_q[k] <= '0;
      seg_value_q <= '0;
      seg_en_q    <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      deb_cnt_q   <= '0;
      edge_q      <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      cap_we_q    <= cap_we_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      addr_err_q  <= addr_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      for (int k = 0; k < N_OUT; k++) led_q[k] <= led_d[k];
      seg_value_q <= seg_value_d;
      seg_en_q    <= seg_en_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      deb_cnt_q   <= deb_cnt_d;
      edge_q      <= edge_d;
    end
  end

  // Next-state logic; request fields are captured on accept
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    cap_we_d    = cap_we_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cap_we_d    = req_we;
          cap_addr_d  = req_addr;
          cap_wdata_d = req_wdata;
          wait_cnt_d  = '0;
          state_d     = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == WS_W'(WAIT_STATES - 1)) state_d = S_RESP;
        else wait_cnt_d = wait_cnt_q + WS_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so use live request fields
  always_comb begin
    acc_we    = cap_we_q;
    acc_addr  = cap_addr_q;
    acc_wdata = cap_wdata_q;
    if (state_q == S_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  assign commit = (state_d == S_RESP);

  // Address decode and read mux
  always_comb begin
    acc_off   = acc_addr - IO_BASE;
    acc_hit   = 1'b0;
    acc_rdata = '0;
    led_hit   = '0;
    if ((acc_off < WIN_SIZE) && (acc_addr[1:0] == 2'b00)) begin
      if (acc_off == OFF_SW) begin
        acc_hit   = 1'b1;
        acc_rdata = 32'(stable_q);
      end else if (acc_off == OFF_SWEDGE) begin
        acc_hit   = 1'b1;
        acc_rdata = 32'(edge_q);
      end else if (acc_off == OFF_SEGVAL) begin
        acc_hit   = 1'b1;
        acc_rdata = seg_value_q;
      end else if (acc_off == OFF_SEGEN) begin
        acc_hit   = 1'b1;
        acc_rdata = {31'b0, seg_en_q};
      end else begin
        for (int k = 0; k < N_OUT; k++) begin
          if (acc_off == OFF_LED + 32'(4 * k)) begin
            acc_hit    = 1'b1;
            led_hit[k] = 1'b1;
            acc_rdata  = 32'(led_q[k]);
          end
        end
      end
    end
  end

  // Register writes, taken on the edge entering RESP
  always_comb begin
    for (int k = 0; k < N_OUT; k++) led_d[k] = led_q[k];
    seg_value_d = seg_value_q;
    seg_en_d    = seg_en_q;
    edge_clr    = '0;
    if (commit && acc_we && acc_hit) begin
      if (acc_off == OFF_SWEDGE) edge_clr = acc_wdata[IN_W-1:0];
      if (acc_off == OFF_SEGVAL) seg_value_d = acc_wdata;
      if (acc_off == OFF_SEGEN)  seg_en_d = acc_wdata[0];
      for (int k = 0; k < N_OUT; k++) begin
        if (led_hit[k]) led_d[k] = acc_wdata[OUT_W-1:0];
      end
    end
  end

  // FSM outputs, registered from the next state
  always_comb begin
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    addr_err_d  = commit && !acc_hit;
    rsp_rdata_d = rsp_rdata_q;
    if (commit) rsp_rdata_d = acc_we ? 32'h0 : acc_rdata;
  end

  // Synchroniser, shared-counter debounce, sticky rising-edge flags (set beats clear)
  always_comb begin
    sync1_d   = sw_in;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q == stable_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == CNT_W'(DEB_CYC - 1)) begin
      stable_d  = sync2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + CNT_W'(1);
    end
    edge_d = (edge_q & ~edge_clr) | (stable_d & ~stable_q);
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign addr_err  = addr_err_q;
  assign seg_value = seg_value_q;
  assign seg_en    = seg_en_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_led
    assign led_out[k*OUT_W +: OUT_W] = led_q[k];
  end

endmodule

// File: tb/tb_mmio_io_hub.sv
// Bench for mmio_io_hub: two instances (0 and 3 wait states) driven by a
// vector table, hand-written debounce/W1C/reset sequences and a random model check.
module tb_mmio_io_hub;

  localparam logic [31:0] BASE = 32'hFFFF_FC00;
  localparam int unsigned NO  = 2;
  localparam int unsigned OW  = 16;
  localparam int unsigned IW  = 16;
  localparam int unsigned DEB = 8;
  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic clk = 1'b0;
  logic rst;
  logic [IW-1:0] sw_in;

  logic rv0, rw0, rr0, rsv0, ae0, se0;
  logic [31:0] ra0, rwd0, rd0, sv0;
  logic [NO*OW-1:0] led0;
  logic rv1, rw1, rr1, rsv1, ae1, se1;
  logic [31:0] ra1, rwd1, rd1, sv1;
  logic [NO*OW-1:0] led1;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  mmio_io_hub #(.IO_BASE(BASE), .N_OUT(NO), .OUT_W(OW), .IN_W(IW), .DEB_CYC(DEB), .WAIT_STATES(WS0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_we(rw0), .req_addr(ra0), .req_wdata(rwd0),
    .req_ready(rr0), .rsp_valid(rsv0), .rsp_rdata(rd0), .addr_err(ae0), .sw_in(sw_in),
    .led_out(led0), .seg_value(sv0), .seg_en(se0));

  mmio_io_hub #(.IO_BASE(BASE), .N_OUT(NO), .OUT_W(OW), .IN_W(IW), .DEB_CYC(DEB), .WAIT_STATES(WS1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_we(rw1), .req_addr(ra1), .req_wdata(rwd1),
    .req_ready(rr1), .rsp_valid(rsv1), .rsp_rdata(rd1), .addr_err(ae1), .sw_in(sw_in),
    .led_out(led1), .seg_value(sv1), .seg_en(se1));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t tbl[$];

  // Reference model state, per instance
  logic [15:0] m_led [2][2];
  logic [31:0] m_seg [2];
  logic        m_en [2];
  logic [15:0] m_flags [2];
  logic [15:0] m_stable;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic ready_of(input int s);  return (s != 0) ? rr1 : rr0;   endfunction
  function automatic logic rspv_of(input int s);   return (s != 0) ? rsv1 : rsv0; endfunction
  function automatic logic err_of(input int s);    return (s != 0) ? ae1 : ae0;   endfunction
  function automatic logic [31:0] rdata_of(input int s); return (s != 0) ? rd1 : rd0; endfunction
  function automatic logic [31:0] led_of(input int s);   return (s != 0) ? led1 : led0; endfunction
  function automatic logic [31:0] seg_of(input int s);   return (s != 0) ? sv1 : sv0; endfunction
  function automatic logic segen_of(input int s);  return (s != 0) ? se1 : se0;   endfunction

  task automatic drive(input int s, input logic v, input logic we, input logic [31:0] a, input logic [31:0] wd);
    if (s == 0) begin rv0 = v; rw0 = we; ra0 = a; rwd0 = wd; end
    else        begin rv1 = v; rw1 = we; ra1 = a; rwd1 = wd; end
  endtask

  // One full access: checks latency, ready-low span and single-cycle rsp pulse
  task automatic do_access(input int s, input logic we, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err);
    int n, lat, low, ws;
    ws = (s != 0) ? WS1 : WS0;
    n = 0;
    @(negedge clk);
    while (!ready_of(s) && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin n_tot++; $display("FAIL ready_timeout: req_ready low for %0d cycles, required idle", n); end
    drive(s, 1'b1, we, a, wd);
    @(posedge clk); #1;
    drive(s, 1'b0, 1'($urandom), $urandom, $urandom);
    lat = 1; low = 0;
    while (!rspv_of(s) && lat < 40) begin
      if (!ready_of(s)) low++;
      @(posedge clk); #1;
      lat++;
    end
    if (!ready_of(s)) low++;
    chk("latency", 32'(lat), 32'(ws + 1));
    chk("ready_low", 32'(low), 32'(ws + 1));
    rd = rdata_of(s);
    err = err_of(s);
    @(posedge clk); #1;
    chk("rsp_pulse", {30'b0, rspv_of(s), ready_of(s)}, 32'h1);
  endtask

  task automatic chk_reset(input int s, input string tag);
    chk({tag, "_ready"}, {31'b0, ready_of(s)}, 32'h1);
    chk({tag, "_rspv"},  {31'b0, rspv_of(s)}, 32'h0);
    chk({tag, "_err"},   {31'b0, err_of(s)}, 32'h0);
    chk({tag, "_rdata"}, rdata_of(s), 32'h0);
    chk({tag, "_led"},   led_of(s), 32'h0);
    chk({tag, "_seg"},   seg_of(s), 32'h0);
    chk({tag, "_segen"}, {31'b0, segen_of(s)}, 32'h0);
  endtask

  // Trial for set-vs-clear race: sw_in[0] rises, then an access to SW/SWEDGE is accepted d edges later
  task automatic edge_trial(input int d, input logic we, output logic [31:0] rd);
    int n;
    @(negedge clk);
    sw_in[0] = 1'b1;
    repeat (d - 1) @(negedge clk);
    drive(0, 1'b1, we, we ? BASE + 32'h4 : BASE, 32'h1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    n = 0;
    while (!rsv0 && n < 20) begin @(posedge clk); #1; n++; end
    rd = rd0;
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee, input string nm);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = wd; v.exp_rd = er; v.exp_err = ee; v.name = nm;
    return v;
  endfunction

  // Behavioural register map
  task automatic model_access(input int s, input logic we, input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err);
    logic [31:0] off;
    off = a - BASE;
    rd = 32'h0;
    err = 1'b0;
    if (a[1:0] != 2'b00 || off >= 32'h400) begin
      err = 1'b1;
    end else begin
      case (off)
        32'h00: rd = {16'h0, m_stable};
        32'h04: begin rd = {16'h0, m_flags[s]}; if (we) m_flags[s] = m_flags[s] & ~wd[15:0]; end
        32'h10: begin rd = {16'h0, m_led[s][0]}; if (we) m_led[s][0] = wd[15:0]; end
        32'h14: begin rd = {16'h0, m_led[s][1]}; if (we) m_led[s][1] = wd[15:0]; end
        32'h20: begin rd = m_seg[s]; if (we) m_seg[s] = wd; end
        32'h24: begin rd = {31'h0, m_en[s]}; if (we) m_en[s] = wd[0]; end
        default: err = 1'b1;
      endcase
    end
    if (we) rd = 32'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, rsw, off;
    logic err, ee;
    logic [15:0] prev, nxt;
    int n_zero, n_rsp;
    logic [31:0] offs [10];

    rst = 1'b1;
    sw_in = '0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #12;
    chk_reset(0, "rst0");
    chk_reset(1, "rst1");
    @(negedge clk);
    rst = 1'b0;

    // Vector table, applied to both instances
    tbl.push_back(mk(1'b1, BASE + 32'h10,  32'h0000_A5A5, 32'h0,         1'b0, "wr_led0"));
    tbl.push_back(mk(1'b0, BASE + 32'h10,  32'h0,         32'h0000_A5A5, 1'b0, "rd_led0"));
    tbl.push_back(mk(1'b1, BASE + 32'h14,  32'hFFFF_1234, 32'h0,         1'b0, "wr_led1"));
    tbl.push_back(mk(1'b0, BASE + 32'h14,  32'h0,         32'h0000_1234, 1'b0, "rd_led1"));
    tbl.push_back(mk(1'b1, BASE + 32'h20,  32'h1234_5678, 32'h0,         1'b0, "wr_segval"));
    tbl.push_back(mk(1'b0, BASE + 32'h20,  32'h0,         32'h1234_5678, 1'b0, "rd_segval"));
    tbl.push_back(mk(1'b1, BASE + 32'h24,  32'hFFFF_FFFF, 32'h0,         1'b0, "wr_segen"));
    tbl.push_back(mk(1'b0, BASE + 32'h24,  32'h0,         32'h0000_0001, 1'b0, "rd_segen"));
    tbl.push_back(mk(1'b0, BASE + 32'h30,  32'h0,         32'h0,         1'b1, "rd_unmapped"));
    tbl.push_back(mk(1'b0, BASE + 32'h10,  32'h0,         32'h0000_A5A5, 1'b0, "rd_led0_b"));
    tbl.push_back(mk(1'b1, BASE + 32'h11,  32'h0000_DEAD, 32'h0,         1'b1, "wr_misalign"));
    tbl.push_back(mk(1'b0, BASE + 32'h10,  32'h0,         32'h0000_A5A5, 1'b0, "rd_led0_c"));
    tbl.push_back(mk(1'b1, 32'h0000_0100,  32'h0000_BEEF, 32'h0,         1'b1, "wr_outside"));
    tbl.push_back(mk(1'b0, 32'h0000_0100,  32'h0,         32'h0,         1'b1, "rd_outside"));
    tbl.push_back(mk(1'b1, BASE + 32'h18,  32'h0000_7777, 32'h0,         1'b1, "wr_led2"));
    tbl.push_back(mk(1'b0, BASE + 32'h3FC, 32'h0,         32'h0,         1'b1, "rd_top"));
    tbl.push_back(mk(1'b0, BASE - 32'h4,   32'h0,         32'h0,         1'b1, "rd_below"));
    tbl.push_back(mk(1'b1, BASE + 32'h400, 32'h0000_1111, 32'h0,         1'b1, "wr_above"));

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < tbl.size(); i++) begin
        do_access(s, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, err);
        chk({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rd);
        chk({tbl[i].name, "_err"}, {31'b0, err}, {31'b0, tbl[i].exp_err});
      end
      chk("tbl_led_out", led_of(s), 32'h1234_A5A5);
      chk("tbl_seg_value", seg_of(s), 32'h1234_5678);
      chk("tbl_seg_en", {31'b0, segen_of(s)}, 32'h1);
    end

    // Debounce: short glitch is dropped, long level is accepted
    @(negedge clk); sw_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    sw_in[0] = 1'b0;
    repeat (20) @(negedge clk);
    do_access(0, 1'b0, BASE, 32'h0, rd, err);        chk("glitch_sw", rd, 32'h0);
    do_access(0, 1'b0, BASE + 32'h4, 32'h0, rd, err); chk("glitch_edge", rd, 32'h0);
    @(negedge clk); sw_in[0] = 1'b1;
    repeat (12) @(negedge clk);
    do_access(0, 1'b0, BASE, 32'h0, rd, err);        chk("held_sw", rd, 32'h1);
    do_access(0, 1'b0, BASE + 32'h4, 32'h0, rd, err); chk("held_edge", rd, 32'h1);
    do_access(1, 1'b0, BASE, 32'h0, rd, err);        chk("held_sw_ws3", rd, 32'h1);

    // W1C behaviour
    @(negedge clk); sw_in[1] = 1'b1;
    repeat (14) @(negedge clk);
    do_access(0, 1'b0, BASE + 32'h4, 32'h0, rd, err); chk("edge_both", rd, 32'h3);
    do_access(0, 1'b1, BASE + 32'h4, 32'h1, rd, err);
    do_access(0, 1'b0, BASE + 32'h4, 32'h0, rd, err); chk("w1c_bit0", rd, 32'h2);
    do_access(0, 1'b1, BASE + 32'h4, 32'h2, rd, err);
    do_access(0, 1'b0, BASE + 32'h4, 32'h0, rd, err); chk("w1c_bit1", rd, 32'h0);

    // Set-vs-clear race: sweep the clear across the rising edge of stable[0]
    sw_in[0] = 1'b0;
    repeat (20) @(negedge clk);
    do_access(0, 1'b1, BASE + 32'h4, 32'h1, rd, err);
    n_zero = 0;
    for (int d = 6; d <= 14; d++) begin
      edge_trial(d, 1'b0, rsw);
      if (rsw[0] == 1'b0) n_zero++;
      sw_in[0] = 1'b0;
      repeat (20) @(negedge clk);
      do_access(0, 1'b1, BASE + 32'h4, 32'h1, rd, err);
      edge_trial(d, 1'b1, rd);
      repeat (15) @(negedge clk);
      do_access(0, 1'b0, BASE + 32'h4, 32'h0, rd, err);
      chk($sformatf("set_wins_d%0d", d), {31'b0, rd[0]}, {31'b0, ~rsw[0]});
      sw_in[0] = 1'b0;
      repeat (20) @(negedge clk);
      do_access(0, 1'b1, BASE + 32'h4, 32'h1, rd, err);
    end
    chk("rise_in_sweep", {31'b0, (n_zero > 0) && (n_zero < 9)}, 32'h1);

    // Random traffic against the behavioural model
    prev = sw_in;
    for (int s = 0; s < 2; s++) do_access(s, 1'b1, BASE + 32'h4, 32'hFFFF_FFFF, rd, err);
    nxt = 16'($urandom);
    sw_in = nxt;
    repeat (20) @(negedge clk);
    m_stable = nxt;
    for (int s = 0; s < 2; s++) begin
      m_flags[s] = nxt & ~prev;
      m_led[s][0] = 16'hA5A5;
      m_led[s][1] = 16'h1234;
      m_seg[s] = 32'h1234_5678;
      m_en[s] = 1'b1;
    end
    offs = '{32'h00, 32'h04, 32'h10, 32'h14, 32'h18, 32'h20, 32'h24, 32'h30, 32'h3FC, 32'h12};
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 120; i++) begin
        logic we;
        logic [31:0] a, wd, er;
        we = 1'($urandom);
        wd = $urandom;
        off = offs[$urandom_range(0, 9)];
        a = BASE + off;
        if ($urandom_range(0, 7) == 0) a = $urandom & 32'hFFFF_FFFC;
        model_access(s, we, a, wd, er, ee);
        do_access(s, we, a, wd, rd, err);
        chk($sformatf("rnd%0d_%0d_rdata", s, i), rd, er);
        chk($sformatf("rnd%0d_%0d_err", s, i), {31'b0, err}, {31'b0, ee});
      end
      chk("rnd_led_out", led_of(s), {m_led[s][1], m_led[s][0]});
      chk("rnd_seg_value", seg_of(s), m_seg[s]);
      chk("rnd_seg_en", {31'b0, segen_of(s)}, {31'b0, m_en[s]});
    end

    // Asynchronous reset mid-cycle, no clock edge before sampling
    do_access(0, 1'b0, BASE + 32'h20, 32'h0, rd, err);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk_reset(0, "arst0");
    chk_reset(1, "arst1");
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a wait-state write aborts it
    @(negedge clk);
    drive(1, 1'b1, 1'b1, BASE + 32'h20, 32'hCAFE_F00D);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_ready", {31'b0, rr1}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    n_rsp = 0;
    repeat (8) begin @(posedge clk); #1; if (rsv1) n_rsp++; end
    chk("abort_no_rsp", 32'(n_rsp), 32'h0);
    chk("abort_seg_value", sv1, 32'h0);
    do_access(1, 1'b0, BASE + 32'h20, 32'h0, rd, err);
    chk("abort_rd_segval", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
